return_stack: RTL and testbench

- Hardware call/return address stack: the responder to the controller's push/pop strobes.
- On JSB the controller asserts push with the return PC; this block stores it.
- On RET the controller asserts pop and selects pc_mux=2'b11; this block has already presented the saved PC combinationally on top_addr.
- Sits beside the PC register in the datapath. It also reports depth and sticky overflow/underflow faults for debug.

---
 rtl/return_stack_if.sv | 29 ++
 rtl/return_stack.sv | 93 +++++++++
 tb/tb_return_stack.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/return_stack_if.sv
// Push/pop bus between the controller and the call/return address stack.
interface return_stack_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 4
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              flush;
  logic              clear_err;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  // controller side: issues strobes, consumes the top address and status
  modport master (
    output push, pop, push_addr, flush, clear_err,
    input  top_addr, count, empty, full, overflow, underflow
  );

  // stack side
  modport slave (
    input  push, pop, push_addr, flush, clear_err,
    output top_addr, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Hardware call/return address stack. The top entry is presented
// combinationally so the RET cycle can steer it straight into the PC mux.
module return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic reset,
  return_stack_if.slave rs
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [CNT_W-1:0]  sp_m1;
  logic [CNT_W-2:0]  wr_idx;
  logic [CNT_W-2:0]  top_idx;
  logic              is_empty;
  logic              is_full;
  logic              do_push;
  logic              do_replace;
  logic              do_pop;
  logic              set_ovf;
  logic              set_udf;
  logic              overflow_q;
  logic              underflow_q;

  // Decode this cycle's operation; flush masks every push/pop effect.
  // A push+pop on an empty stack degenerates into a plain push.
  always_comb begin
    sp_m1      = sp - 1'b1;
    top_idx    = sp_m1[CNT_W-2:0];
    wr_idx     = sp[CNT_W-2:0];
    is_empty   = (sp == '0);
    is_full    = (sp == FULL_CNT);
    do_replace = !rs.flush && rs.push && rs.pop && !is_empty;
    do_push    = !rs.flush && rs.push && (!rs.pop || is_empty) && !is_full;
    do_pop     = !rs.flush && rs.pop && !rs.push && !is_empty;
    set_ovf    = !rs.flush && rs.push && !rs.pop && is_full;
    set_udf    = !rs.flush && rs.pop && is_empty;
  end

  // Stack pointer, entry storage and sticky fault flags; a new fault wins over clear_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp          <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (rs.flush) begin
        sp <= '0;
      end else if (do_push) begin
        sp <= sp + 1'b1;
      end else if (do_pop) begin
        sp <= sp_m1;
      end

      if (do_push) begin
        mem[wr_idx] <= rs.push_addr;
      end else if (do_replace) begin
        mem[top_idx] <= rs.push_addr;
      end

      if (set_ovf) begin
        overflow_q <= 1'b1;
      end else if (rs.clear_err) begin
        overflow_q <= 1'b0;
      end

      if (set_udf) begin
        underflow_q <= 1'b1;
      end else if (rs.clear_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Status and top-of-stack view; popped entries stay in mem but are never shown.
  always_comb begin
    rs.top_addr  = is_empty ? '0 : mem[top_idx];
    rs.count     = sp;
    rs.empty     = is_empty;
    rs.full      = is_full;
    rs.overflow  = overflow_q;
    rs.underflow = underflow_q;
  end

endmodule

// File: tb/tb_return_stack.sv
`timescale 1ns/100ps
// Self-checking bench for return_stack against a queue-based stack model.
module tb_return_stack;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;

  return_stack_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) rs_if ();

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // reference model: visible entries, bottom first
  logic [ADDR_W-1:0] q [$];
  logic              m_ovf;
  logic              m_udf;

  function automatic logic [ADDR_W+CNT_W+3:0] exp_vec();
    logic [ADDR_W-1:0] t;
    t = (q.size() != 0) ? q[q.size()-1] : '0;
    return {t, CNT_W'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf, m_udf};
  endfunction

  function automatic logic [ADDR_W+CNT_W+3:0] obs_vec();
    return {rs_if.top_addr, rs_if.count, rs_if.empty, rs_if.full,
            rs_if.overflow, rs_if.underflow};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // applies the currently driven strobes to the model as one clock edge
  task automatic model_edge();
    logic nu, no;
    no = rs_if.clear_err ? 1'b0 : m_ovf;
    nu = rs_if.clear_err ? 1'b0 : m_udf;
    if (rs_if.flush) begin
      q.delete();
      no = m_ovf;
      nu = m_udf;
      if (rs_if.clear_err) begin
        no = 1'b0;
        nu = 1'b0;
      end
    end else if (rs_if.push && rs_if.pop) begin
      if (q.size() != 0) q[q.size()-1] = rs_if.push_addr;
      else begin
        q.push_back(rs_if.push_addr);
        nu = 1'b1;
      end
    end else if (rs_if.push) begin
      if (q.size() < DEPTH) q.push_back(rs_if.push_addr);
      else no = 1'b1;
    end else if (rs_if.pop) begin
      if (q.size() != 0) void'(q.pop_back());
      else nu = 1'b1;
    end
    m_ovf = no;
    m_udf = nu;
  endtask

  task automatic drive(input logic p, input logic po, input logic [ADDR_W-1:0] a,
                       input logic fl, input logic ce);
    rs_if.push      = p;
    rs_if.pop       = po;
    rs_if.push_addr = a;
    rs_if.flush     = fl;
    rs_if.clear_err = ce;
  endtask

  // one clock: model follows the edge, then strobes return to idle
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic settle_empty();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #12 reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    vectors++;
    if ({rs_if.count, rs_if.empty, rs_if.top_addr} !== {4'd0, 1'b1, 12'h000}) begin
      miscompares++;
      $display("FAIL reset_const: count=%0d empty=%b top=%h", rs_if.count, rs_if.empty, rs_if.top_addr);
    end
  endtask

  task automatic test_push_pop();
    logic [ADDR_W-1:0] vals [3];
    vals[0] = 12'h010; vals[1] = 12'h020; vals[2] = 12'h030;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, vals[i], 1'b0, 1'b0);
      tick();
    end
    vectors++;
    if ({rs_if.count, rs_if.top_addr} !== {4'd3, 12'h030}) begin
      miscompares++;
      $display("FAIL push3: count=%0d top=%h expected 3 030", rs_if.count, rs_if.top_addr);
    end
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (rs_if.top_addr !== 12'h030) begin
      miscompares++;
      $display("FAIL pop_cycle_top: got %h expected 030", rs_if.top_addr);
    end
    tick();
    vectors++;
    if ({rs_if.count, rs_if.top_addr} !== {4'd2, 12'h020} || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL after_pop: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    settle_empty();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, ADDR_W'(i), 1'b0, 1'b0);
      tick();
      if (i == 8) begin
        vectors++;
        if (rs_if.full !== 1'b1 || rs_if.overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL full_at_8: full=%b ovf=%b expected 1 0", rs_if.full, rs_if.overflow);
        end
      end
    end
    vectors++;
    if ({rs_if.overflow, rs_if.top_addr, rs_if.count} !== {1'b1, 12'h008, 4'd8}) begin
      miscompares++;
      $display("FAIL overflow_9th: ovf=%b top=%h count=%0d expected 1 008 8",
               rs_if.overflow, rs_if.top_addr, rs_if.count);
    end
    for (int i = 8; i >= 1; i--) begin
      vectors++;
      if (rs_if.top_addr !== ADDR_W'(i)) begin
        miscompares++;
        $display("FAIL drain_top: got %h expected %h", rs_if.top_addr, ADDR_W'(i));
      end
      drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
      tick();
    end
    vectors++;
    if (rs_if.empty !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL drained: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_underflow();
    settle_empty();
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({rs_if.underflow, rs_if.count, rs_if.top_addr} !== {1'b1, 4'd0, 12'h000}) begin
      miscompares++;
      $display("FAIL empty_pop: udf=%b count=%0d top=%h", rs_if.underflow, rs_if.count, rs_if.top_addr);
    end
    drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
    tick();
    vectors++;
    if (rs_if.underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL set_beats_clear: udf=%b expected 1", rs_if.underflow);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    vectors++;
    if (rs_if.underflow !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL clear_err: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_replace();
    settle_empty();
    drive(1'b1, 1'b0, 12'h010, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 12'h020, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 12'h055, 1'b0, 1'b0); tick();
    vectors++;
    if ({rs_if.top_addr, rs_if.count, rs_if.overflow, rs_if.underflow} !== {12'h055, 4'd2, 2'b00}) begin
      miscompares++;
      $display("FAIL replace: top=%h count=%0d flags=%b%b expected 055 2 00",
               rs_if.top_addr, rs_if.count, rs_if.overflow, rs_if.underflow);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, ADDR_W'(12'h100 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({rs_if.top_addr, rs_if.full, rs_if.overflow} !== {12'hABC, 1'b1, 1'b0} || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL replace_full: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush();
    settle_empty();
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, ADDR_W'(12'h200 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 12'h777, 1'b1, 1'b0);
    tick();
    vectors++;
    if ({rs_if.count, rs_if.empty, rs_if.top_addr, rs_if.overflow, rs_if.underflow}
        !== {4'd0, 1'b1, 12'h000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL flush: got %h expected count=0 empty top=0 ovf=0 udf=1", obs_vec());
    end
  endtask

  task automatic test_random();
    logic p, po, fl, ce;
    for (int n = 0; n < 400; n++) begin
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      ce = ($urandom_range(0, 99) < 8);
      drive(p, po, ADDR_W'($urandom), fl, ce);
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_pre[%0d]: got %h expected %h", n, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, ADDR_W'(12'h300 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    tick();
    #1 reset = 1'b0;
    model_reset();
    #0.5;
    vectors++;
    if ({rs_if.count, rs_if.empty, rs_if.full, rs_if.top_addr, rs_if.overflow, rs_if.underflow}
        !== {4'd0, 1'b1, 1'b0, 12'h000, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected reset values", obs_vec());
    end
    #0.5 reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL post_reset: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
